// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock parametrised FIFO with occupancy count,
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and
// a synchronous clear.
//
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through reads
// (data_out shows mem[rd_ptr] combinationally, r_en pops). Without it,
// data_out is a register loaded on each accepted read (1-cycle latency).
//
// Flags and count are registered and always derived from the next count,
// never from pointer comparison, so full/empty are unambiguous across wrap.

module sync_fifo_flags #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned AFULL_THRESH  = DEPTH - 2,
    parameter int unsigned AEMPTY_THRESH = 1,
    localparam int unsigned ADDR_W       = $clog2(DEPTH),
    localparam int unsigned CNT_W        = ADDR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AFULL  = CNT_W'(AFULL_THRESH);
    localparam logic [CNT_W-1:0] CNT_AEMPTY = CNT_W'(AEMPTY_THRESH);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit above the array index.
    logic [CNT_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  rd_ptr;
    logic [ADDR_W-1:0] wr_idx;
    logic [ADDR_W-1:0] rd_idx;

    logic              wr_acc_c;
    logic              rd_acc_c;
    logic [CNT_W-1:0]  count_nxt_c;

    assign wr_idx = wr_ptr[ADDR_W-1:0];
    assign rd_idx = rd_ptr[ADDR_W-1:0];

    // Acceptance from the registered flags, and the occupancy after this edge.
    always_comb begin
        wr_acc_c    = w_en & ~full;
        rd_acc_c    = r_en & ~empty;
        count_nxt_c = count;
        unique case ({wr_acc_c, rd_acc_c})
            2'b10:   count_nxt_c = count + CNT_ONE;
            2'b01:   count_nxt_c = count - CNT_ONE;
            default: count_nxt_c = count;
        endcase
    end

    // Pointers, count, status flags and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else if (clr) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc_c) begin
                wr_ptr <= wr_ptr + CNT_ONE;
            end
            if (rd_acc_c) begin
                rd_ptr <= rd_ptr + CNT_ONE;
            end
            count        <= count_nxt_c;
            full         <= (count_nxt_c == CNT_FULL);
            empty        <= (count_nxt_c == '0);
            almost_full  <= (count_nxt_c >= CNT_AFULL);
            almost_empty <= (count_nxt_c <= CNT_AEMPTY);
            overflow     <= overflow  | (w_en & full);
            underflow    <= underflow | (r_en & empty);
        end
    end

    // Storage array; contents survive clr and reset.
    always_ff @(posedge clk) begin
        if (wr_acc_c && !clr) begin
            mem[wr_idx] <= data_in;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word presented combinationally; meaningless while empty.
    always_comb begin
        data_out = mem[rd_idx];
    end
`else
    // Registered read port: loads the head word on each accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (rd_acc_c && !clr) begin
            data_out <= mem[rd_idx];
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags (DEPTH 8, AFULL 6, AEMPTY 1).
// Reference model: a queue of words plus two sticky bits.

module tb_sync_fifo_flags;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AF    = 6;
    localparam int unsigned AE    = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          w_en;
    logic          r_en;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [3:0]    count;
    logic          overflow;
    logic          underflow;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    logic          m_ovf;
    logic          m_unf;
    logic [DW-1:0] m_dout;

    always #5 clk = ~clk;

    sync_fifo_flags #(
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .AFULL_THRESH (AF),
        .AEMPTY_THRESH(AE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .w_en        (w_en),
        .data_in     (data_in),
        .r_en        (r_en),
        .data_out    (data_out),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_dout = '0;
    endtask

    // Compare every output against the model's view of the FIFO.
    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".count"},        32'(count),        32'(n));
        chk({tag, ".empty"},        32'(empty),        32'(n == 0));
        chk({tag, ".full"},         32'(full),         32'(n == DEPTH));
        chk({tag, ".almost_full"},  32'(almost_full),  32'(n >= AF));
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= AE));
        chk({tag, ".overflow"},     32'(overflow),     32'(m_ovf));
        chk({tag, ".underflow"},    32'(underflow),    32'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
        if (n != 0) chk({tag, ".data_out"}, 32'(data_out), 32'(q[0]));
`else
        chk({tag, ".data_out"}, 32'(data_out), 32'(m_dout));
`endif
    endtask

    // One clock: drive inputs, update model at the edge, check on the falling edge.
    task automatic step(input logic we, input logic re, input logic cl,
                        input logic [DW-1:0] d, input string tag);
        int  n;
        logic wa;
        logic ra;
        w_en    = we;
        r_en    = re;
        clr     = cl;
        data_in = d;
        @(posedge clk);
        n = q.size();
        if (cl) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            wa = we && (n < DEPTH);
            ra = re && (n > 0);
            if (we && n == DEPTH) m_ovf = 1'b1;
            if (re && n == 0)     m_unf = 1'b1;
            if (ra) m_dout = q.pop_front();
            if (wa) q.push_back(d);
        end
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        rst_n   = 1'b0;
        clr     = 1'b0;
        w_en    = 1'b0;
        r_en    = 1'b0;
        data_in = '0;
        model_reset();

        // Reset held for 3 cycles
        repeat (3) @(negedge clk);
        check_all("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all("after_reset");
        chk("reset.data_out", 32'(data_out), 32'h0);

        // Fill 0x10..0x17, then one write too many
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, DW'(8'h10 + i), "fill");
        chk("fill.full", 32'(full), 32'd1);
        step(1'b1, 1'b0, 1'b0, 8'h99, "fill_over");
        chk("fill_over.count", 32'(count), 32'd8);
        chk("fill_over.overflow", 32'(overflow), 32'd1);

        // Drain in order, then one read too many
`ifdef SYNC_FIFO_FWFT_EN
        chk("fwft.head", 32'(data_out), 32'h10);
`endif
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00, "drain");
`ifndef SYNC_FIFO_FWFT_EN
            chk("drain.value", 32'(data_out), 32'(8'h10 + i));
`endif
        end
        step(1'b0, 1'b1, 1'b0, 8'h00, "drain_under");
        chk("drain_under.underflow", 32'(underflow), 32'd1);
        chk("drain_under.empty", 32'(empty), 32'd1);

        // Simultaneous access at count 4 across pointer wrap
        step(1'b0, 1'b0, 1'b1, 8'h00, "clr1");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, DW'(8'h20 + i), "pre4");
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, DW'(8'h24 + i), "simul");
            chk("simul.count4", 32'(count), 32'd4);
        end
        chk("simul.no_err", 32'({overflow, underflow}), 32'd0);

        // Full with simultaneous write and read
        step(1'b0, 1'b0, 1'b1, 8'h00, "clr2");
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, DW'(8'h40 + i), "fill2");
        step(1'b1, 1'b1, 1'b0, 8'h77, "full_wr");
        chk("full_wr.count", 32'(count), 32'd7);
        chk("full_wr.overflow", 32'(overflow), 32'd1);

        // Empty with simultaneous write and read
        step(1'b0, 1'b0, 1'b1, 8'h00, "clr3");
        step(1'b1, 1'b1, 1'b0, 8'hA5, "empty_wr");
        chk("empty_wr.count", 32'(count), 32'd1);
        chk("empty_wr.underflow", 32'(underflow), 32'd1);
        step(1'b0, 1'b1, 1'b0, 8'h00, "empty_wr_rd");
`ifndef SYNC_FIFO_FWFT_EN
        chk("empty_wr_rd.data", 32'(data_out), 32'hA5);
`endif

        // clr at count 5 together with a write
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, DW'(8'h50 + i), "fill5");
        step(1'b1, 1'b1, 1'b1, 8'hEE, "clr_wr");
        chk("clr_wr.count", 32'(count), 32'd0);
        chk("clr_wr.empty", 32'(empty), 32'd1);

        // Random traffic with an asynchronous reset pulse mid-stream
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                step(1'b1, 1'b0, 1'b0, 8'h3C, "pre_rst");
                #2 rst_n = 1'b0;
                model_reset();
                #1 check_all("async_rst");
                @(negedge clk);
                rst_n = 1'b1;
                check_all("async_rst_rel");
            end
            step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 3, DW'($urandom), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
